uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_bit_sampler.sv | 54 +++++
 rtl/uart_rx_cfg.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared FSM encoding, parity-mode codes and legal parameter limits
// Revision : 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_sampler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_bit_sampler : per-bit oversample tick counter with 2-of-3 centre vote
// Revision : 1.0
// ---------------------------------------------------------------------------
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          baud_tick,
  input  logic                          rx,
  input  logic                          restart,
  input  logic                          run,
  output logic                          bit_done,
  output logic                          bit_val,
  output logic [$clog2(OVERSAMPLE)-1:0] tick_cnt
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TICK_EARLY  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] TICK_CENTRE = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] TICK_LATE   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] TICK_LAST   = CW'(OVERSAMPLE - 1);

  logic s_early, s_mid;

  // The tick that detects the falling edge is tick 0 of the start bit,
  // so a restart loads 1 for the following tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      s_early  <= 1'b1;
      s_mid    <= 1'b1;
    end else if (baud_tick) begin
      if (restart) begin
        tick_cnt <= CW'(1);
      end else if (run) begin
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + CW'(1);
        if (tick_cnt == TICK_EARLY)  s_early <= rx;
        if (tick_cnt == TICK_CENTRE) s_mid   <= rx;
      end else begin
        tick_cnt <= '0;
      end
    end
  end

  assign bit_done = run && baud_tick && (tick_cnt == TICK_LATE);
  assign bit_val  = maj3(s_early, s_mid, rx);

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_cfg : oversampled UART receiver with valid/ready output and error
//               pulses; parity support compiled in with UART_RX_PARITY_EN.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 serial,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]  TICK_CENTRE = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0]  TICK_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_DATA   = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP   = BCW'(STOP_BITS - 1);

  logic                 sync1, sync2, rx;
  rx_state_t            state, state_nxt;
  logic [CW-1:0]        tick_cnt;
  logic                 bit_done, bit_val, start_ok;
  logic [DATA_BITS-1:0] shreg;
  logic [BCW-1:0]       bit_cnt;
  logic                 all_low, par_bad, parity_on;
  logic                 frame_good, frame_fe, frame_brk, frame_pe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= serial;
      sync2 <= sync1;
    end
  end
  assign rx = sync2;

  assign start_ok = (state == ST_START) && baud_tick && (tick_cnt == TICK_CENTRE) && !rx;

  uart_bit_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk       (clk),
    .reset_n   (reset_n),
    .baud_tick (baud_tick),
    .rx        (rx),
    .restart   ((state == ST_IDLE) && !rx),
    .run       ((state == ST_START) || (state == ST_DATA) ||
                (state == ST_PARITY) || (state == ST_STOP)),
    .bit_done  (bit_done),
    .bit_val   (bit_val),
    .tick_cnt  (tick_cnt)
  );

`ifdef UART_RX_PARITY_EN
  logic [1:0] par_mode;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_mode   <= PAR_NONE;
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= frame_pe;
      if (start_ok) begin
        par_mode <= parity_mode;
        par_bad  <= 1'b0;
      end else if ((state == ST_PARITY) && bit_done) begin
        par_bad <= bit_val != ((^shreg) ^ (par_mode == PAR_ODD));
      end
    end
  end
  assign parity_on = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
  assign parity_on  = 1'b0;
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_good = 1'b0;
    frame_fe   = 1'b0;
    frame_brk  = 1'b0;
    frame_pe   = 1'b0;
    case (state)
      ST_IDLE:  if (baud_tick && !rx) state_nxt = ST_START;
      ST_START: begin
        if (baud_tick) begin
          if ((tick_cnt == TICK_CENTRE) && rx) state_nxt = ST_IDLE;
          else if (tick_cnt == TICK_LAST)      state_nxt = ST_DATA;
        end
      end
      ST_DATA:  if (bit_done && (bit_cnt == LAST_DATA))
                  state_nxt = parity_on ? ST_PARITY : ST_STOP;
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (bit_done) state_nxt = ST_STOP;
`endif
      ST_STOP: begin
        if (bit_done) begin
          // An all-low frame through the first stop bit is a line break.
          if (!bit_val) begin
            state_nxt = ST_WAIT_IDLE;
            if ((bit_cnt == '0) && all_low) frame_brk = 1'b1;
            else                            frame_fe  = 1'b1;
          end else if (bit_cnt == LAST_STOP) begin
            state_nxt = ST_IDLE;
            if (par_bad) frame_pe   = 1'b1;
            else         frame_good = 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: if (baud_tick && rx) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      all_low <= 1'b0;
    end else if (start_ok) begin
      bit_cnt <= '0;
      all_low <= 1'b1;
    end else if (bit_done) begin
      case (state)
        ST_DATA: begin
          shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
          all_low <= all_low & ~bit_val;
          bit_cnt <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + BCW'(1);
        end
        ST_PARITY: all_low <= all_low & ~bit_val;
        ST_STOP:   bit_cnt <= bit_cnt + BCW'(1);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data        <= '0;
      valid       <= 1'b0;
      framing_err <= 1'b0;
      break_det   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= frame_fe;
      break_det   <= frame_brk;
      overrun     <= 1'b0;
      if (frame_good) begin
        if (valid && !ready) begin
          overrun <= 1'b1;
        end else begin
          data  <= shreg;
          valid <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg : directed bench for uart_rx_cfg (8N1, OVERSAMPLE=4)
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       reset_n, baud_tick, serial, ready;
  logic [1:0] parity_mode;
  logic [7:0] data;
  logic       valid, framing_err, parity_err, overrun, break_det;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0, n_fe = 0, n_pe = 0, n_ovr = 0, n_brk = 0;
  int v0, f0, p0, o0, b0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(4), .STOP_BITS(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .baud_tick   (baud_tick),
    .serial      (serial),
    .parity_mode (parity_mode),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .framing_err (framing_err),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .break_det   (break_det)
  );

`ifdef UART_RX_PARITY_EN
  logic [6:0] data_p;
  logic       valid_p, fe_p, pe_p, ovr_p, brk_p;
  int         np_valid = 0, np_pe = 0, np_other = 0;

  uart_rx_cfg #(.DATA_BITS(7), .OVERSAMPLE(4), .STOP_BITS(1)) dut_p (
    .clk         (clk),
    .reset_n     (reset_n),
    .baud_tick   (baud_tick),
    .serial      (serial),
    .parity_mode (2'b10),
    .data        (data_p),
    .valid       (valid_p),
    .ready       (ready),
    .framing_err (fe_p),
    .parity_err  (pe_p),
    .overrun     (ovr_p),
    .break_det   (brk_p)
  );

  always @(negedge clk) begin
    if (valid_p) np_valid++;
    if (pe_p) np_pe++;
    if (fe_p || ovr_p || brk_p) np_other++;
  end
`endif

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (valid) n_valid++;
    if (framing_err) n_fe++;
    if (parity_err) n_pe++;
    if (overrun) n_ovr++;
    if (break_det) n_brk++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic snap();
    v0 = n_valid; f0 = n_fe; p0 = n_pe; o0 = n_ovr; b0 = n_brk;
  endtask

  task automatic check_deltas(input string tag, input int ev, input int ef,
                              input int eb, input int eo);
    check({tag, ".valid_cycles"}, n_valid - v0, ev);
    check({tag, ".framing_err"}, n_fe - f0, ef);
    check({tag, ".break_det"}, n_brk - b0, eb);
    check({tag, ".overrun"}, n_ovr - o0, eo);
    check({tag, ".parity_err"}, n_pe - p0, 0);
  endtask

  // One bit time is 16 clocks; glitch inverts clocks 6..9 (one tick) of the bit.
  task automatic drive_bit(input logic b, input logic glitch);
    for (int c = 0; c < 16; c++) begin
      serial = (glitch && c >= 6 && c < 10) ? ~b : b;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input logic par_en,
                            input logic par_bit, input logic stop_val, input int glitch_bit);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i], glitch_bit == i);
    if (par_en) drive_bit(par_bit, 1'b0);
    drive_bit(stop_val, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         exp_valid;
    int         exp_fe;
    int         exp_brk;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 0, 1, 0, 8'hFF};
    vecs[4] = '{8'h00, 1'b0, 0, 0, 1, 8'hFF};
    vecs[5] = '{8'h80, 1'b1, 1, 0, 0, 8'h80};

    reset_n     = 1'b0;
    serial      = 1'b1;
    ready       = 1'b1;
    parity_mode = 2'b11;
    repeat (4) @(negedge clk);
    check("reset.data", int'(data), 0);
    check("reset.valid", int'(valid), 0);
    check("reset.framing_err", int'(framing_err), 0);
    check("reset.parity_err", int'(parity_err), 0);
    check("reset.overrun", int'(overrun), 0);
    check("reset.break_det", int'(break_det), 0);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      snap();
      send_frame({1'b0, vecs[i].d}, 8, 1'b0, 1'b0, vecs[i].stop, -1);
      check($sformatf("vec%0d.data", i), int'(data), int'(vecs[i].exp_data));
      check_deltas($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_fe,
                   vecs[i].exp_brk, 0);
    end

    // Start-bit glitch of one tick must not start a frame.
    snap();
    serial = 1'b0;
    repeat (4) @(negedge clk);
    serial = 1'b1;
    repeat (12 * 16) @(negedge clk);
    check_deltas("glitch_start", 0, 0, 0, 0);

    // Single corrupted sample inside data bit 2 is outvoted.
    snap();
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 2);
    check("glitch_data.data", int'(data), 32'hA5);
    check_deltas("glitch_data", 1, 0, 0, 0);

    // Overrun: second word is discarded while the first is held.
    ready = 1'b0;
    snap();
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1, -1);
    check("ovr.first_data", int'(data), 32'h11);
    check("ovr.first_valid", int'(valid), 1);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1, -1);
    check("ovr.held_data", int'(data), 32'h11);
    check("ovr.held_valid", int'(valid), 1);
    check("ovr.pulses", n_ovr - o0, 1);
    ready = 1'b1;
    @(negedge clk);
    check("ovr.valid_cleared", int'(valid), 0);
    check("ovr.data_kept", int'(data), 32'h11);

    // Break: line low for 12 bit times, then a normal frame.
    snap();
    serial = 1'b0;
    repeat (12 * 16) @(negedge clk);
    serial = 1'b1;
    repeat (2 * 16) @(negedge clk);
    check_deltas("break", 0, 0, 1, 0);
    snap();
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, -1);
    check("after_break.data", int'(data), 32'h3C);
    check_deltas("after_break", 1, 0, 0, 0);

    // Reset mid-data of 0xFF, then a clean 0x81.
    snap();
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset.data", int'(data), 0);
    check("midreset.valid", int'(valid), 0);
    @(negedge clk);
    serial = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3 * 16) @(negedge clk);
    check_deltas("midreset", 0, 0, 0, 0);
    snap();
    send_frame(9'h081, 8, 1'b0, 1'b0, 1'b1, -1);
    check("after_reset.data", int'(data), 32'h81);
    check_deltas("after_reset", 1, 0, 0, 0);

`ifdef UART_RX_PARITY_EN
    // 0x55 in 7 bits has four ones, so odd parity requires a 1.
    begin
      int pv, pp, po;
      pv = np_valid; pp = np_pe; po = np_other;
      send_frame(9'h055, 7, 1'b1, 1'b0, 1'b1, -1);
      check("par_bad.parity_err", np_pe - pp, 1);
      check("par_bad.valid_cycles", np_valid - pv, 0);
      check("par_bad.other_flags", np_other - po, 0);
      pv = np_valid; pp = np_pe;
      send_frame(9'h055, 7, 1'b1, 1'b1, 1'b1, -1);
      check("par_ok.parity_err", np_pe - pp, 0);
      check("par_ok.valid_cycles", np_valid - pv, 1);
      check("par_ok.data", int'(data_p), 32'h55);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
